protein_assay_sequencer: RTL
============================

Name: protein_assay_sequencer

Overview:
- Digital controller for the opposite end of the colorimetric protein assay chip interface.
- Drives the chip's dispense actuations: one sample valve plus N_BUF buffer valves.
- After incubation, captures the N_OPT optical detector outputs and returns one result word to the host over a valid/ready handshake.
- Sits between the host control logic and the assay fluidic netlist.

Parameters:
- N_BUF, 39, number of buffer dispense valves
- N_OPT, 8, number of optical detector channels
- PULSE_W, 4, valve-open cycles per dispense (>=1)
- GAP_W, 2, all-valves-closed cycles after each dispense (>=1)
- INCUB_CYC, 64, incubation cycles before detection (>=1)
- TIMEOUT_CYC, 1024, maximum detection window in cycles (>=1)
- CNT_W, 16, width of the internal timer; must hold the largest of the above

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin one assay run; sampled only in IDLE
- abort  in  1  cancel the run in progress
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a reported result is accepted
- dsp_sample  out  1  sample dispense valve drive
- dsp_buffer  out  N_BUF  buffer valve drives; bit k drives buffer k+1
- opt_in  in  N_OPT  raw detector outputs, asynchronous to clk
- res_valid  out  1  result available
- res_ready  in  1  host accepts the result
- res_data  out  N_OPT  sticky detector hits
- res_timeout  out  1  detection window expired before all channels hit

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; all outputs 0, including every valve, res_data and res_timeout; counters, hit register and synchronizers cleared.
- All outputs are registered.
- At most one valve output may be high in any cycle (one-hot or zero).
- States: IDLE, SAMPLE, GAP_S, BUF, GAP_B, INCUB, DETECT, REPORT.
- IDLE:
  - start=1 and abort=0 at edge T0 -> SAMPLE; busy=1 from T0+1.
  - start while busy is ignored.
- SAMPLE: dsp_sample=1 for cycles T0+1..T0+PULSE_W, then GAP_S for GAP_W cycles.
- BUF / GAP_B:
  - Buffer index k runs 0..N_BUF-1 in order.
  - dsp_buffer[k]=1 for PULSE_W cycles starting at T0+1+(k+1)*(PULSE_W+GAP_W), followed by GAP_W closed cycles.
  - After the last gap (k=N_BUF-1) -> INCUB.
  - Defaults: last buffer is open T0+235..T0+238; INCUB spans T0+241..T0+304.
- INCUB: all valves 0 for INCUB_CYC cycles, then DETECT (default entry at T0+305).
- Detector synchronizer: opt_in passes through a 2-flop synchronizer that runs continuously.
- DETECT:
  - Hit register cleared on entry.
  - Each cycle: hit |= opt_sync.
  - Timer counts from 0.
  - Exit to REPORT when hit is all ones (res_timeout=0), or after TIMEOUT_CYC DETECT cycles (res_timeout=1).
  - If both occur in the same cycle, all-ones wins: res_timeout=0.
  - Detector activity before DETECT is ignored.
- REPORT:
  - res_valid=1; res_data and res_timeout hold stable while res_valid=1 and res_ready=0.
  - On res_valid and res_ready in the same cycle: next cycle res_valid=0, done=1 for one cycle, state IDLE, busy=0.
  - res_data and res_timeout keep their last values until the next DETECT entry.
- Abort:
  - abort=1 in any non-IDLE state, including REPORT -> next cycle IDLE, all valves 0, res_valid=0, busy=0, no done.
  - abort has priority over every other transition.
  - abort in IDLE is ignored; if start=1 in the same cycle, start is ignored too.
- Reset mid-run: immediate asynchronous return to the reset values; no partial result is reported.
- Timers saturate and never wrap within a state.

Test Plan:
- Full run, opt_in=0xFF held from T0: valve order is sample, then buffers 1..39, each open 4 cycles with 2 closed between; never two valves high; dsp_buffer[38] high T0+235..T0+238; res_valid within 3 cycles of DETECT entry with res_data=0xFF, res_timeout=0; done pulses once.
- opt_in=0x0F throughout the run: res_valid exactly TIMEOUT_CYC=1024 cycles after DETECT entry; res_data=0x0F, res_timeout=1.
- Single-cycle glitches on individual channels during DETECT, channels 0..7 at different times: res_data=0xFF (sticky); opt_in=0xFF pulsed only during INCUB: hit cleared on DETECT entry -> timeout with res_data=0x00.
- res_ready held low for 10 cycles in REPORT: res_valid, res_data and res_timeout stable throughout; after the handshake, done=1 for exactly one cycle, then busy=0.
- abort while dsp_buffer[9]=1: next cycle all valves 0, busy=0, no res_valid and no done; a new start then rerun completes normally.
- rst_n pulled low while dsp_sample=1: outputs 0 immediately; start re-accepted after rst_n=1; start asserted mid-run: no effect on the valve sequence.

Source files
------------

// File: rtl/protein_assay_sequencer.sv
// Assay sequencer: drives sample/buffer dispense valves, incubates, then collects
// sticky optical detector hits and hands one result word to the host.
module protein_assay_sequencer #(
  parameter int N_BUF       = 39,
  parameter int N_OPT       = 8,
  parameter int PULSE_W     = 4,
  parameter int GAP_W       = 2,
  parameter int INCUB_CYC   = 64,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             dsp_sample,
  output logic [N_BUF-1:0] dsp_buffer,
  input  logic [N_OPT-1:0] opt_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N_OPT-1:0] res_data,
  output logic             res_timeout
);

  localparam int BI_W = (N_BUF > 1) ? $clog2(N_BUF) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0] INCUB_LAST = CNT_W'(INCUB_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [BI_W-1:0]  BUF_LAST   = BI_W'(N_BUF - 1);

  typedef enum logic [2:0] {
    IDLE, SAMPLE, GAP_S, BUF, GAP_B, INCUB, DETECT, REPORT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BI_W-1:0]    buf_idx_q, buf_idx_d;
  logic [N_OPT-1:0]   hit_q, hit_d;
  logic [N_OPT-1:0]   opt_s1_q, opt_s2_q;
  logic [N_OPT-1:0]   res_data_q, res_data_d;
  logic               res_timeout_q, res_timeout_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               res_valid_q, res_valid_d;
  logic               dsp_sample_q, dsp_sample_d;
  logic [N_BUF-1:0]   dsp_buffer_q, dsp_buffer_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d       = state_q;
    buf_idx_d     = buf_idx_q;
    hit_d         = hit_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    done_d        = 1'b0;
    unique case (state_q)
      IDLE:   if (start && !abort) state_d = SAMPLE;
      SAMPLE: if (cnt_q == PULSE_LAST) state_d = GAP_S;
      GAP_S: begin
        if (cnt_q == GAP_LAST) begin
          state_d   = BUF;
          buf_idx_d = '0;
        end
      end
      BUF:    if (cnt_q == PULSE_LAST) state_d = GAP_B;
      GAP_B: begin
        if (cnt_q == GAP_LAST) begin
          if (buf_idx_q == BUF_LAST) begin
            state_d = INCUB;
          end else begin
            state_d   = BUF;
            buf_idx_d = buf_idx_q + 1'b1;
          end
        end
      end
      INCUB: begin
        if (cnt_q == INCUB_LAST) begin
          state_d       = DETECT;
          hit_d         = '0;
          res_data_d    = '0;
          res_timeout_d = 1'b0;
        end
      end
      DETECT: begin
        // A full hit set in the final window cycle still counts as success.
        hit_d = hit_q | opt_s2_q;
        if (&hit_d) begin
          state_d       = REPORT;
          res_data_d    = hit_d;
          res_timeout_d = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d       = REPORT;
          res_data_d    = hit_d;
          res_timeout_d = 1'b1;
        end
      end
      REPORT: begin
        if (res_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d       = IDLE;
      done_d        = 1'b0;
      buf_idx_d     = buf_idx_q;
      res_data_d    = res_data_q;
      res_timeout_d = res_timeout_q;
    end

    cnt_d = (state_d != state_q) ? '0 : sat_inc(cnt_q);
  end

  // Outputs are registered decodes of the next state so they line up with it.
  always_comb begin
    busy_d       = (state_d != IDLE);
    res_valid_d  = (state_d == REPORT);
    dsp_sample_d = (state_d == SAMPLE);
    dsp_buffer_d = '0;
    if (state_d == BUF) dsp_buffer_d[buf_idx_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      buf_idx_q     <= '0;
      hit_q         <= '0;
      opt_s1_q      <= '0;
      opt_s2_q      <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      dsp_sample_q  <= 1'b0;
      dsp_buffer_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      buf_idx_q     <= buf_idx_d;
      hit_q         <= hit_d;
      opt_s1_q      <= opt_in;
      opt_s2_q      <= opt_s1_q;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      res_valid_q   <= res_valid_d;
      dsp_sample_q  <= dsp_sample_d;
      dsp_buffer_q  <= dsp_buffer_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign dsp_sample  = dsp_sample_q;
  assign dsp_buffer  = dsp_buffer_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;

endmodule
